deltaw3_gen: RTL

Layer-3 weight-update generator for the DQN training datapath. Computes the 5×4 array of weight deltas `deltaw3_ij = -(err_j · a2_i) >> (FRAC_BITS+LR_SHIFT)` with one time-shared multiplier, then holds the results stable for the layer-3 weight bank. That bank adds the deltas on its update cycle. This block is the producer side of the `deltaw3_*` interface.

---
 rtl/dqn_pkg.sv | 19 +
 rtl/deltaw3_gen_mul_shift_sat.sv | 31 +++
 rtl/deltaw3_gen.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/dqn_pkg.sv
// Shared definitions for the DQN training datapath: word format, layer sizes,
// FSM encoding and Q8.8 saturation limits.
package dqn_pkg;
    localparam int WORD_W        = 16;
    localparam int N_H2          = 5;
    localparam int N_OUT         = 4;
    localparam int N_ELEM        = N_H2 * N_OUT;
    localparam int DEF_FRAC_BITS = 8;
    localparam int DEF_LR_SHIFT  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic signed [WORD_W-1:0] Q_MAX = 16'sh7FFF;
    localparam logic signed [WORD_W-1:0] Q_MIN = 16'sh8000;
endpackage

// File: rtl/deltaw3_gen_mul_shift_sat.sv
// Combinational delta element: d = sat16(-((err * a2) >>> (FRAC_BITS+LR_SHIFT))).
module mul_shift_sat
    import dqn_pkg::*;
#(
    parameter int FRAC_BITS = DEF_FRAC_BITS,
    parameter int LR_SHIFT  = DEF_LR_SHIFT
) (
    input  logic signed [WORD_W-1:0] err_i,
    input  logic signed [WORD_W-1:0] a2_i,
    output logic signed [WORD_W-1:0] delta_o
);
    logic signed [2*WORD_W-1:0] prod;
    logic signed [2*WORD_W-1:0] shifted;
    logic signed [2*WORD_W:0]   shifted_ext;
    logic signed [2*WORD_W:0]   neg;

    always_comb begin
        prod        = err_i * a2_i;
        shifted     = prod >>> (FRAC_BITS + LR_SHIFT);
        // One extra bit so negating the most negative shifted value cannot wrap
        shifted_ext = {shifted[2*WORD_W-1], shifted};
        neg         = -shifted_ext;
        if (neg > 33'sd32767) begin
            delta_o = Q_MAX;
        end else if (neg < -33'sd32768) begin
            delta_o = Q_MIN;
        end else begin
            delta_o = neg[WORD_W-1:0];
        end
    end
endmodule

// File: rtl/deltaw3_gen.sv
// Layer-3 weight-delta generator: 20 deltas computed one per cycle through a
// single shared multiplier, then held in output registers for the weight bank.
module deltaw3_gen
    import dqn_pkg::*;
#(
    parameter int FRAC_BITS = DEF_FRAC_BITS,
    parameter int LR_SHIFT  = DEF_LR_SHIFT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic signed [WORD_W-1:0] err_1,
    input  logic signed [WORD_W-1:0] err_2,
    input  logic signed [WORD_W-1:0] err_3,
    input  logic signed [WORD_W-1:0] err_4,
    input  logic signed [WORD_W-1:0] a2_1,
    input  logic signed [WORD_W-1:0] a2_2,
    input  logic signed [WORD_W-1:0] a2_3,
    input  logic signed [WORD_W-1:0] a2_4,
    input  logic signed [WORD_W-1:0] a2_5,
    output logic signed [WORD_W-1:0] deltaw3_11,
    output logic signed [WORD_W-1:0] deltaw3_12,
    output logic signed [WORD_W-1:0] deltaw3_13,
    output logic signed [WORD_W-1:0] deltaw3_14,
    output logic signed [WORD_W-1:0] deltaw3_21,
    output logic signed [WORD_W-1:0] deltaw3_22,
    output logic signed [WORD_W-1:0] deltaw3_23,
    output logic signed [WORD_W-1:0] deltaw3_24,
    output logic signed [WORD_W-1:0] deltaw3_31,
    output logic signed [WORD_W-1:0] deltaw3_32,
    output logic signed [WORD_W-1:0] deltaw3_33,
    output logic signed [WORD_W-1:0] deltaw3_34,
    output logic signed [WORD_W-1:0] deltaw3_41,
    output logic signed [WORD_W-1:0] deltaw3_42,
    output logic signed [WORD_W-1:0] deltaw3_43,
    output logic signed [WORD_W-1:0] deltaw3_44,
    output logic signed [WORD_W-1:0] deltaw3_51,
    output logic signed [WORD_W-1:0] deltaw3_52,
    output logic signed [WORD_W-1:0] deltaw3_53,
    output logic signed [WORD_W-1:0] deltaw3_54,
    output logic                     busy,
    output logic                     done
);
    localparam int K_W = $clog2(N_ELEM);

    state_t                   state_q, state_d;
    logic [K_W-1:0]           k_q, k_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     load, wr_en;
    logic signed [WORD_W-1:0] err_q   [N_OUT];
    logic signed [WORD_W-1:0] a2_q    [N_H2];
    logic signed [WORD_W-1:0] delta_q [N_ELEM];
    logic signed [WORD_W-1:0] delta_w;

    // k = 4*(i-1) + (j-1): low two bits pick the error, upper bits the activation
    mul_shift_sat #(
        .FRAC_BITS(FRAC_BITS),
        .LR_SHIFT (LR_SHIFT)
    ) u_mss (
        .err_i  (err_q[k_q[1:0]]),
        .a2_i   (a2_q[k_q[K_W-1:2]]),
        .delta_o(delta_w)
    );

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        load    = 1'b0;
        wr_en   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    k_d     = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                wr_en = 1'b1;
                if (k_q == K_W'(N_ELEM - 1)) begin
                    k_d     = '0;
                    state_d = DONE;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_q == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            k_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= '{default: '0};
            a2_q    <= '{default: '0};
            delta_q <= '{default: '0};
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            if (load) begin
                err_q <= '{err_1, err_2, err_3, err_4};
                a2_q  <= '{a2_1, a2_2, a2_3, a2_4, a2_5};
            end
            if (wr_en) begin
                delta_q[k_q] <= delta_w;
            end
        end
    end

    assign busy = busy_q;
    assign done = done_q;

    assign deltaw3_11 = delta_q[0];
    assign deltaw3_12 = delta_q[1];
    assign deltaw3_13 = delta_q[2];
    assign deltaw3_14 = delta_q[3];
    assign deltaw3_21 = delta_q[4];
    assign deltaw3_22 = delta_q[5];
    assign deltaw3_23 = delta_q[6];
    assign deltaw3_24 = delta_q[7];
    assign deltaw3_31 = delta_q[8];
    assign deltaw3_32 = delta_q[9];
    assign deltaw3_33 = delta_q[10];
    assign deltaw3_34 = delta_q[11];
    assign deltaw3_41 = delta_q[12];
    assign deltaw3_42 = delta_q[13];
    assign deltaw3_43 = delta_q[14];
    assign deltaw3_44 = delta_q[15];
    assign deltaw3_51 = delta_q[16];
    assign deltaw3_52 = delta_q[17];
    assign deltaw3_53 = delta_q[18];
    assign deltaw3_54 = delta_q[19];
endmodule
